// File: rtl/board_dump_tx.sv
// Streams the 144-byte board map + life table out of RAM as 8N1 UART frames, then an XOR checksum frame.
// Latency: first start bit 3 cycles after start is sampled; 10*CLKS_PER_BIT+2 cycles per memory byte.
// Backpressure: none; the UART line is paced by the baud counter and start is ignored while busy.
module board_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAP_BYTES    = 128,
    parameter int LIFE_BYTES   = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       mem_rd,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       tx
);

    localparam int TOTAL = MAP_BYTES + LIFE_BYTES;
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    LAST_IDX  = 8'(TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_CHKLOAD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    idx;
    logic [7:0]    chk;
    logic [7:0]    shift_reg;
    logic          is_chk;     // current frame is the checksum, not a RAM byte
    logic          bit_end;
    logic          in_frame;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign in_frame = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    assign mem_addr = idx;

    // State register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_START;
            S_START:   if (bit_end) state_nxt = S_DATA;
            S_DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    if (is_chk)                state_nxt = S_IDLE;
                    else if (idx == LAST_IDX)  state_nxt = S_CHKLOAD;
                    else                       state_nxt = S_FETCH;
                end
            end
            S_CHKLOAD: state_nxt = S_START;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs; tx falls back to idle-high whenever the FSM is in IDLE (including under reset)
    always_comb begin
        busy   = (state != S_IDLE);
        mem_rd = (state == S_FETCH);
        tx     = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

    // Baud counter and bit index: restart at every bit boundary and outside a frame
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
        end else begin
            if (in_frame && !bit_end) baud_cnt <= baud_cnt + 1'b1;
            else                      baud_cnt <= '0;

            if (state != S_DATA)  bit_idx <= 3'd0;
            else if (bit_end)     bit_idx <= bit_idx + 3'd1;
        end
    end

    // Byte datapath: address walk, running XOR, shift register and done pulse
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            idx       <= 8'd0;
            chk       <= 8'd0;
            shift_reg <= 8'd0;
            is_chk    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == S_STOP) && bit_end && is_chk;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx    <= 8'd0;
                        chk    <= 8'd0;
                        is_chk <= 1'b0;
                    end
                end
                S_LOAD: begin
                    shift_reg <= mem_rdata;
                    chk       <= chk ^ mem_rdata;
                end
                S_DATA: begin
                    if (bit_end) shift_reg <= {1'b0, shift_reg[7:1]};
                end
                S_STOP: begin
                    if (bit_end && !is_chk && idx != LAST_IDX) idx <= idx + 8'd1;
                end
                S_CHKLOAD: begin
                    shift_reg <= chk;
                    is_chk    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_dump_tx.sv
// Directed bench for board_dump_tx: RAM model, UART frame decoder and cycle-exact timing checks.
// Latency: a full dump is DONE_CYC cycles with the reduced baud divisor used here.
// Backpressure: not applicable; stimulus is start pulses, RAM contents and reset.
module tb_board_dump_tx;

    localparam int C        = 4;
    localparam int P        = 10 * C + 2;
    localparam int TOTAL    = 144;
    localparam int CHK_START = 2 + TOTAL * P;          // checksum start bit cycle
    localparam int DONE_CYC = CHK_START + 10 * C;       // done pulse cycle

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       tx;

    logic [7:0] mem [0:255];

    int cnt  = 0;
    int base = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic done_busy;

    logic [7:0] rx_byte [$];
    int         rx_cyc  [$];
    int         rx_lows [$];
    logic       rx_stop [$];
    logic [7:0] addr_q  [$];
    int         done_q  [$];

    board_dump_tx #(.CLKS_PER_BIT(C), .MAP_BYTES(128), .LIFE_BYTES(16)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .tx       (tx)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cnt <= cnt + 1;

    // Synchronous RAM: data valid the cycle after the read strobe
    always @(posedge CLOCK_50) if (mem_rd) mem_rdata <= mem[mem_addr];

    // Log read addresses and done pulses with their cycle number
    always @(negedge CLOCK_50) begin
        if (mem_rd) addr_q.push_back(mem_addr);
        if (done) begin
            done_q.push_back(cnt - base);
            done_busy = busy;
        end
    end

    // UART receiver: locks on the first low cycle, samples each bit mid-cell
    initial begin : uart_rx
        logic [7:0] b;
        int lows;
        int sc;
        logic stp;
        forever begin
            @(negedge CLOCK_50);
            if (tx === 1'b0) begin
                sc   = cnt - base;
                lows = 0;
                for (int i = 0; i < C; i++) begin
                    if (i > 0) @(negedge CLOCK_50);
                    if (tx === 1'b0) lows++;
                end
                for (int bi = 0; bi < 8; bi++) begin
                    repeat ((bi == 0) ? (C / 2 + 1) : C) @(negedge CLOCK_50);
                    b[bi] = tx;
                end
                repeat (C) @(negedge CLOCK_50);
                stp = tx;
                repeat (C - C / 2 - 1) @(negedge CLOCK_50);
                rx_byte.push_back(b);
                rx_cyc.push_back(sc);
                rx_lows.push_back(lows);
                rx_stop.push_back(stp);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rx_byte.delete();
        rx_cyc.delete();
        rx_lows.delete();
        rx_stop.delete();
        addr_q.delete();
        done_q.delete();
    endtask

    // pattern 0: all zero; 1: map 2,4,6,8,10 = 0x01, life = 0x03; 2: byte 0 = 0xA5
    task automatic load_mem(input int pat);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        if (pat == 1) begin
            for (int i = 2; i <= 10; i += 2) mem[i] = 8'h01;
            for (int i = 128; i < 144; i++) mem[i] = 8'h03;
        end else if (pat == 2) begin
            mem[0] = 8'hA5;
        end
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50);
        start = 1'b1;
        base  = cnt;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    // Runs one dump for a fixed window past the done cycle, re-pulsing start at p1/p2
    task automatic run_dump(input int p1, input int p2);
        clear_logs();
        done_busy = 1'b1;
        pulse_start();
        while ((cnt - base) < DONE_CYC + 20) begin
            @(negedge CLOCK_50);
            start = ((cnt - base) == p1) || ((cnt - base) == p2);
        end
        start = 1'b0;
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp_chk);
        int bad_b;
        int bad_t;
        int bad_a;
        check_val({tag, "_frames"}, rx_byte.size(), TOTAL + 1);
        check_val({tag, "_reads"}, addr_q.size(), TOTAL);
        check_val({tag, "_done_cnt"}, done_q.size(), 1);
        if (rx_byte.size() == TOTAL + 1) begin
            bad_b = 0;
            bad_t = 0;
            for (int i = 0; i < TOTAL; i++) begin
                if (rx_byte[i] !== mem[i]) bad_b++;
                if (rx_cyc[i] != 3 + P * i) bad_t++;
            end
            for (int i = 0; i <= TOTAL; i++) begin
                if (rx_lows[i] != C || rx_stop[i] !== 1'b1) bad_t++;
            end
            check_val({tag, "_bytes_bad"}, bad_b, 0);
            check_val({tag, "_timing_bad"}, bad_t, 0);
            check_val({tag, "_checksum"}, rx_byte[TOTAL], exp_chk);
            check_val({tag, "_chk_start"}, rx_cyc[TOTAL], CHK_START);
        end
        if (addr_q.size() == TOTAL) begin
            bad_a = 0;
            for (int i = 0; i < TOTAL; i++) if (addr_q[i] != 8'(i)) bad_a++;
            check_val({tag, "_addr_bad"}, bad_a, 0);
        end
        if (done_q.size() > 0) begin
            check_val({tag, "_done_cyc"}, done_q[0], DONE_CYC);
            check_val({tag, "_busy_at_done"}, done_busy, 1'b0);
        end
        check_val({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        load_mem(0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_val("rst_outputs", {tx, busy, done, mem_rd}, 4'b1000);
        check_val("rst_addr", mem_addr, 8'h00);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Idle with no start
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            check_val("idle_outputs", {tx, busy, done, mem_rd}, 4'b1000);
        end

        load_mem(1);
        run_dump(-1, -1);
        check_stream("pattern", 8'h01);
        if (rx_byte.size() > 0) check_val("first_start_cyc", rx_cyc[0], 3);

        load_mem(0);
        run_dump(-1, -1);
        check_stream("zero", 8'h00);

        load_mem(2);
        run_dump(-1, -1);
        check_stream("a5", 8'hA5);
        if (rx_byte.size() > 0) check_val("a5_first_frame", rx_byte[0], 8'hA5);

        // Extra start pulses mid-dump must be ignored
        load_mem(1);
        run_dump(100, 3000);
        check_stream("restart_ign", 8'h01);

        // Reset during byte 50's data phase (bit 2, which is a 0 bit)
        clear_logs();
        pulse_start();
        while ((cnt - base) < 3 + 50 * P + 3 * C) @(negedge CLOCK_50);
        check_val("tx_before_rst", tx, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_val("rst_mid_tx", tx, 1'b1);
        check_val("rst_mid_busy", busy, 1'b0);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (12 * C) @(negedge CLOCK_50);
        check_val("rst_mid_no_done", done_q.size(), 0);
        check_val("rst_mid_idle", {tx, busy}, 2'b10);
        run_dump(-1, -1);
        check_stream("after_rst", 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_dump_tx.md
# board_dump_tx

Reads back the 128-byte board map and 16-byte life table from the game's synchronous RAM and streams them to the PC over the UART TX line. It is the reverse direction of the board load path. It runs in CLOCK_50 alongside the game FSM and is triggered by a single start pulse. The stream is 8N1 at 115200 baud: 144 memory bytes in address order, then one XOR checksum byte.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- MAP_BYTES, 128, map bytes, addresses 0..MAP_BYTES-1.
- LIFE_BYTES, 16, life bytes, addresses MAP_BYTES..MAP_BYTES+LIFE_BYTES-1.
- CLOCK_50  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a dump; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the checksum stop bit completes.
- mem_rd  out  1  RAM read strobe, one cycle per byte.
- mem_addr  out  8  RAM byte address (map followed by life table).
- mem_rdata  in  8  RAM read data, valid the cycle after mem_rd.
- tx  out  1  UART serial output, idle high.

## Operation
- States:
  - IDLE
  - FETCH: mem_rd=1, mem_addr=idx.
  - LOAD: shift_reg<=mem_rdata; chk<=chk^mem_rdata.
  - START: tx=0.
  - DATA: 8 bits, LSB first.
  - STOP: tx=1.
  - CHKLOAD: shift_reg<=chk.
- IDLE, start=1: idx<=0, chk<=0, go to FETCH. Otherwise stay; tx=1.
- FETCH to LOAD, then LOAD to START, each takes 1 cycle.
- START, each DATA bit and STOP each last exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts on every bit boundary.
- STOP end:
  - memory byte with idx < MAP_BYTES+LIFE_BYTES-1: idx++, go to FETCH;
  - last memory byte: go to CHKLOAD, then START;
  - checksum byte: done=1, go to IDLE.
- Total bytes on the line are MAP_BYTES+LIFE_BYTES+1, which is 145 at defaults.
- Each address is read exactly once, in ascending order. mem_rd is never asserted outside FETCH.
- start while busy is ignored; no queuing.
- A flag selects whether a byte came from memory or is the checksum. idx is not reused for this, so no wrap-around can occur.
- chk is the 8-bit XOR of all memory bytes. mem_rdata is never summed.

## Timing
- Reset values:
  - tx=1, busy=0, done=0, mem_rd=0, mem_addr=0;
  - state IDLE; idx, chk, shift_reg and baud counter all 0.
- Reset asserted mid-stream: tx goes to 1 immediately (asynchronously), the transfer is abandoned and no done pulse is produced.
- Cycle numbering: cycle 0 is the edge that samples start=1 in IDLE. busy=1 from cycle 1.
- Memory byte k (0-based):
  - FETCH at cycle 1+4342k;
  - LOAD at cycle 2+4342k;
  - start bit starts at cycle 3+4342k.
- Per-byte period is 10*CLKS_PER_BIT+2 = 4342 cycles for memory bytes and 10*CLKS_PER_BIT+1 = 4341 for the checksum.
- At defaults:
  - CHKLOAD at cycle 625,249;
  - checksum start bit at cycle 625,250;
  - last stop-bit cycle is 629,589;
  - done=1, busy=0 and state IDLE at cycle 629,590.
- Inter-byte line idle (tx=1 beyond the stop bit) is exactly 2 cycles for memory bytes and 1 cycle before the checksum.
- done is high for exactly 1 cycle. A new start is accepted at the earliest on the cycle after done.

## Test plan
- Reset, then hold 100 cycles with no start -> tx=1, busy=0, done=0, mem_rd=0 throughout.
- Map bytes 2,4,6,8,10 = 0x01, all other map bytes 0x00, life bytes all 0x03, then pulse start -> bench UART decodes 145 bytes: the map pattern, 16×0x03, checksum 0x01. mem_addr sequence is 0..143, each with exactly one mem_rd cycle.
- Same run, bit timing -> first start bit is low for exactly 434 cycles starting at cycle 3. done pulses exactly once, at cycle 629,590.
- All-zero RAM -> 144×0x00 then checksum 0x00. Byte 0 = 0xA5 with the rest zero -> first frame's bits, LSB first, are 1,0,1,0,0,1,0,1, and checksum is 0xA5.
- Pulse start again at cycle 5000 and cycle 300,000 during a dump -> no restart, byte order and checksum unchanged, single done.
- Assert reset during byte 50's DATA phase -> tx=1 and busy=0 on reset, no done. A fresh start afterwards produces a complete 145-byte stream from address 0.
